// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, state encoding and strobe/flag indices for the ALU op sequencer
package alu_seq_pkg;

    localparam int NUM_STB = 10;

    localparam int unsigned OP_CLR  = 0;
    localparam int unsigned OP_ADD  = 1;
    localparam int unsigned OP_SUB  = 2;
    localparam int unsigned OP_MUL  = 3;
    localparam int unsigned OP_DIV  = 4;
    localparam int unsigned OP_SHR  = 5;
    localparam int unsigned OP_SHL  = 6;
    localparam int unsigned OP_AND  = 7;
    localparam int unsigned OP_OR   = 8;
    localparam int unsigned OP_NOT  = 9;
    localparam int unsigned OP_LOAD = 10;
    localparam int unsigned OP_SHRN = 11;
    localparam int unsigned OP_SHLN = 12;

    // Bit positions in the strobe vector; the trailing comment is the ALU control line.
    localparam int S_CLR = 0;   // C8
    localparam int S_ADD = 1;   // C9
    localparam int S_SUB = 2;   // C13
    localparam int S_MUL = 3;   // C15
    localparam int S_DIV = 4;   // C16
    localparam int S_SHR = 5;   // C17
    localparam int S_SHL = 6;   // C18
    localparam int S_AND = 7;   // C19
    localparam int S_OR  = 8;   // C20
    localparam int S_NOT = 9;   // C21

    localparam int FLAG_ZF = 3;
    localparam int FLAG_CF = 2;
    localparam int FLAG_OF = 1;
    localparam int FLAG_SF = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STEP,
        ST_WAIT,
        ST_RESP
    } seq_state_e;

    function automatic logic [NUM_STB-1:0] stb_bit(input int idx);
        stb_bit = {{(NUM_STB-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/alu_strobe_decode.sv
// rtl/alu_strobe_decode.sv - maps (op, step index) to a one-hot ALU strobe and the command's strobe count
module alu_strobe_decode
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
) (
    input  logic [OP_W-1:0]    op,
    input  logic [DATA_W-1:0]  data,
    input  logic [3:0]         step_idx,
    output logic [NUM_STB-1:0] strobe,
    output logic [4:0]         count,
    output logic               err
);

    int unsigned        op_i;
    logic [NUM_STB-1:0] stb_raw;

    always_comb begin
        op_i    = 32'(op);
        stb_raw = '0;
        count   = 5'd1;
        err     = 1'b0;
        case (op_i)
            OP_CLR: stb_raw = stb_bit(S_CLR);
            OP_ADD: stb_raw = stb_bit(S_ADD);
            OP_SUB: stb_raw = stb_bit(S_SUB);
            OP_MUL: stb_raw = stb_bit(S_MUL);
            OP_DIV: begin
                stb_raw = stb_bit(S_DIV);
                if (data == '0) begin
                    count = 5'd0;
                    err   = 1'b1;
                end
            end
            OP_SHR: stb_raw = stb_bit(S_SHR);
            OP_SHL: stb_raw = stb_bit(S_SHL);
            OP_AND: stb_raw = stb_bit(S_AND);
            OP_OR:  stb_raw = stb_bit(S_OR);
            OP_NOT: stb_raw = stb_bit(S_NOT);
            OP_LOAD: begin
                // LOAD is clear-then-add of the operand bus into the accumulator
                count   = 5'd2;
                stb_raw = (step_idx == 4'd0) ? stb_bit(S_CLR) : stb_bit(S_ADD);
            end
            OP_SHRN: begin
                count   = {1'b0, data[3:0]};
                stb_raw = stb_bit(S_SHR);
            end
            OP_SHLN: begin
                count   = {1'b0, data[3:0]};
                stb_raw = stb_bit(S_SHL);
            end
            default: begin
                count = 5'd0;
                err   = 1'b1;
            end
        endcase
        strobe = ({1'b0, step_idx} < count) ? stb_raw : '0;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command front-end that expands ALU ops into registered strobe sequences
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int OP_W       = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err,
    output logic              busy,
    output logic [DATA_W-1:0] BR_out,
    output logic              C8,
    output logic              C9,
    output logic              C13,
    output logic              C15,
    output logic              C16,
    output logic              C17,
    output logic              C18,
    output logic              C19,
    output logic              C20,
    output logic              C21,
    input  logic [DATA_W-1:0] ALU_out,
    input  logic [3:0]        ALUflags
);

    localparam int WCNT_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

    seq_state_e         state_q;
    logic [OP_W-1:0]    op_q;
    logic [DATA_W-1:0]  br_q;
    logic [3:0]         step_q;
    logic [WCNT_W-1:0]  wcnt_q;
    logic [NUM_STB-1:0] strobe_q;
    logic               rsp_valid_q;
    logic [DATA_W-1:0]  rsp_result_q;
    logic [3:0]         rsp_flags_q;
    logic               rsp_err_q;
    logic               busy_q;
    logic               cmd_ready_q;

    logic [OP_W-1:0]    dec_op;
    logic [DATA_W-1:0]  dec_data;
    logic [NUM_STB-1:0] dec_strobe;
    logic [4:0]         dec_count;
    logic               dec_err;

    // In IDLE the decoder sizes the incoming command; afterwards it only sees the latched copy.
    assign dec_op   = (state_q == ST_IDLE) ? cmd_op   : op_q;
    assign dec_data = (state_q == ST_IDLE) ? cmd_data : br_q;

    alu_strobe_decode #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_decode (
        .op       (dec_op),
        .data     (dec_data),
        .step_idx (step_q),
        .strobe   (dec_strobe),
        .count    (dec_count),
        .err      (dec_err)
    );

    // Strobes lag the STEP state by one cycle, so the first WAIT cycle still carries the
    // last strobe; WAIT therefore runs SETTLE_CYC+1 cycles to give SETTLE_CYC quiet cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            br_q         <= '0;
            step_q       <= '0;
            wcnt_q       <= '0;
            strobe_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    strobe_q <= '0;
                    if (cmd_valid && cmd_ready_q) begin
                        op_q        <= cmd_op;
                        br_q        <= cmd_data;
                        step_q      <= '0;
                        busy_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        if (dec_count == 5'd0) begin
                            state_q <= ST_WAIT;
                            wcnt_q  <= WCNT_W'(SETTLE_CYC);
                        end else begin
                            state_q <= ST_STEP;
                        end
                    end
                end
                ST_STEP: begin
                    strobe_q <= dec_strobe;
                    step_q   <= step_q + 4'd1;
                    if (({1'b0, step_q} + 5'd1) == dec_count) begin
                        state_q <= ST_WAIT;
                        wcnt_q  <= WCNT_W'(SETTLE_CYC);
                    end
                end
                ST_WAIT: begin
                    strobe_q <= '0;
                    if (wcnt_q == '0) begin
                        rsp_result_q <= ALU_out;
                        rsp_flags_q  <= ALUflags;
                        rsp_err_q    <= dec_err;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        wcnt_q <= wcnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    strobe_q <= '0;
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    strobe_q <= '0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;
    assign BR_out     = br_q;

    assign C8  = strobe_q[S_CLR];
    assign C9  = strobe_q[S_ADD];
    assign C13 = strobe_q[S_SUB];
    assign C15 = strobe_q[S_MUL];
    assign C16 = strobe_q[S_DIV];
    assign C17 = strobe_q[S_SHR];
    assign C18 = strobe_q[S_SHL];
    assign C19 = strobe_q[S_AND];
    assign C20 = strobe_q[S_OR];
    assign C21 = strobe_q[S_NOT];

endmodule
